// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Arbitrates a single register-file write port between the write-back
//   stage and a multicycle unit. Multicycle results that cannot be written
//   right away are parked in a small FIFO. A FIFO head that keeps losing to
//   the write-back stage forces a one-cycle DRAIN. During DRAIN the pipeline
//   is frozen and the head is written.
//
//   Ports
//     clk, rst            clock, asynchronous active-low reset
//     wb_valid_i/addr/data  write-back stage result (highest priority)
//     mc_valid_i/addr/data  multicycle unit offer; mc_ready_o accepts it
//     rf_we_o/addr/data     registered register-file write
//     stall_o               registered pipeline freeze (high during DRAIN)
//     fifo_count_o          FIFO occupancy
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   PIPE  | normal arbitration: wb > FIFO head > bypass of a fresh mc result
//   DRAIN | stall_o high, wb ignored, FIFO head written, back to PIPE
module wb_port_arbiter #(
   parameter int N            = 32,
   parameter int ADDR_W       = 5,
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wb_valid_i,
   input  logic [ADDR_W-1:0]        wb_addr_i,
   input  logic [N-1:0]             wb_data_i,
   input  logic                     mc_valid_i,
   input  logic [ADDR_W-1:0]        mc_addr_i,
   input  logic [N-1:0]             mc_data_i,
   output logic                     mc_ready_o,
   output logic                     rf_we_o,
   output logic [ADDR_W-1:0]        rf_addr_o,
   output logic [N-1:0]             rf_data_o,
   output logic                     stall_o,
   output logic [$clog2(DEPTH):0]   fifo_count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam int EW = ADDR_W + N;

   typedef enum logic {PIPE = 1'b0, DRAIN = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       starve_q, starve_d;
   logic [PW:0]         count_q, count_d;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [EW-1:0]       mem_q [DEPTH];

   logic                rf_we_q, rf_we_d;
   logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
   logic [N-1:0]        rf_data_q, rf_data_d;
   logic                stall_q, stall_d;

   logic                fifo_empty;
   logic                hs;
   logic                sel_wb, sel_fifo, sel_byp;
   logic                push, pop;
   logic [EW-1:0]       head;

   assign fifo_empty = (count_q == '0);
   assign mc_ready_o = rst & (count_q != (PW+1)'(DEPTH));
   assign hs         = mc_valid_i & mc_ready_o;
   assign head       = mem_q[rd_ptr_q];

   // Source selection; DRAIN always takes the head, which is never empty there.
   assign sel_wb   = (state_q == PIPE) & wb_valid_i;
   assign sel_fifo = (state_q == DRAIN) | ((state_q == PIPE) & ~wb_valid_i & ~fifo_empty);
   assign sel_byp  = (state_q == PIPE) & ~wb_valid_i & fifo_empty & hs;
   assign pop      = sel_fifo;
   assign push     = hs & ~sel_byp;

   // State register and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= PIPE;
         starve_q  <= '0;
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         rf_we_q   <= 1'b0;
         rf_addr_q <= '0;
         rf_data_q <= '0;
         stall_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         starve_q  <= starve_d;
         count_q   <= count_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         rf_we_q   <= rf_we_d;
         rf_addr_q <= rf_addr_d;
         rf_data_q <= rf_data_d;
         stall_q   <= stall_d;
      end
   end

   // Storage needs no reset: entries are only read behind a valid count.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {mc_addr_i, mc_data_i};
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      case (state_q)
         PIPE: begin
            if (fifo_empty || pop) begin
               starve_d = '0;
            end else if (starve_q == CW'(STARVE_LIMIT - 1)) begin
               state_d  = DRAIN;
               starve_d = '0;
            end else begin
               starve_d = starve_q + 1'b1;
            end
         end
         DRAIN: begin
            state_d  = PIPE;
            starve_d = '0;
         end
         default: begin
            state_d  = PIPE;
            starve_d = '0;
         end
      endcase
   end

   // Output and FIFO bookkeeping logic
   always_comb begin
      rf_addr_d = rf_addr_q;
      rf_data_d = rf_data_q;
      if (sel_wb) begin
         rf_addr_d = wb_addr_i;
         rf_data_d = wb_data_i;
      end else if (sel_fifo) begin
         rf_addr_d = head[EW-1:N];
         rf_data_d = head[N-1:0];
      end else if (sel_byp) begin
         rf_addr_d = mc_addr_i;
         rf_data_d = mc_data_i;
      end
      // R0 writes still consume their source but never reach the file.
      rf_we_d  = (sel_wb | sel_fifo | sel_byp) & (rf_addr_d != '0);
      stall_d  = (state_d == DRAIN);
      count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
   end

   assign rf_we_o      = rf_we_q;
   assign rf_addr_o    = rf_addr_q;
   assign rf_data_o    = rf_data_q;
   assign stall_o      = stall_q;
   assign fifo_count_o = count_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

   logic        clk;
   logic        rst;
   logic        wb_valid_i;
   logic [4:0]  wb_addr_i;
   logic [31:0] wb_data_i;
   logic        mc_valid_i;
   logic [4:0]  mc_addr_i;
   logic [31:0] mc_data_i;
   logic        mc_ready_o;
   logic        rf_we_o;
   logic [4:0]  rf_addr_o;
   logic [31:0] rf_data_o;
   logic        stall_o;
   logic [1:0]  fifo_count_o;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model: queue of pending mc results plus expected registered outputs
   logic [36:0] mq[$];
   bit          m_drain;
   int          m_starve;
   logic        m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   logic        m_stall;

   wb_port_arbiter #(.N(32), .ADDR_W(5), .DEPTH(2), .STARVE_LIMIT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .wb_valid_i   (wb_valid_i),
      .wb_addr_i    (wb_addr_i),
      .wb_data_i    (wb_data_i),
      .mc_valid_i   (mc_valid_i),
      .mc_addr_i    (mc_addr_i),
      .mc_data_i    (mc_data_i),
      .mc_ready_o   (mc_ready_o),
      .rf_we_o      (rf_we_o),
      .rf_addr_o    (rf_addr_o),
      .rf_data_o    (rf_data_o),
      .stall_o      (stall_o),
      .fifo_count_o (fifo_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      else
         n_pass++;
   endtask

   task automatic mwrite(input logic [4:0] a, input logic [31:0] d);
      m_addr = a;
      m_data = d;
      m_we   = (a != 5'd0);
   endtask

   task automatic model_clear();
      mq.delete();
      m_drain  = 0;
      m_starve = 0;
      m_we     = 1'b0;
      m_addr   = '0;
      m_data   = '0;
      m_stall  = 1'b0;
   endtask

   // entered and left one time unit after a rising edge
   task automatic step(input logic wbv, input logic [4:0] wba, input logic [31:0] wbd,
                       input logic mcv, input logic [4:0] mca, input logic [31:0] mcd);
      logic        hs, nonempty, popped, byp;
      logic [36:0] hd;
      wb_valid_i = wbv; wb_addr_i = wba; wb_data_i = wbd;
      mc_valid_i = mcv; mc_addr_i = mca; mc_data_i = mcd;
      #1;
      chk("mc_ready", mc_ready_o, mq.size() < 2);
      chk("count_pre", fifo_count_o, mq.size());
      hs       = mcv && (mq.size() < 2);
      nonempty = (mq.size() != 0);
      popped   = 0;
      byp      = 0;
      m_we     = 1'b0;
      if (m_drain) begin
         hd = mq.pop_front();
         popped = 1;
         mwrite(hd[36:32], hd[31:0]);
         m_drain  = 0;
         m_stall  = 1'b0;
         m_starve = 0;
      end else begin
         if (wbv) mwrite(wba, wbd);
         else if (nonempty) begin
            hd = mq.pop_front();
            popped = 1;
            mwrite(hd[36:32], hd[31:0]);
         end else if (hs) begin
            byp = 1;
            mwrite(mca, mcd);
         end
         if (nonempty && !popped) m_starve++;
         else m_starve = 0;
         m_stall = 1'b0;
         if (m_starve == 4) begin
            m_drain  = 1;
            m_stall  = 1'b1;
            m_starve = 0;
         end
      end
      if (hs && !byp) mq.push_back({mca, mcd});
      @(posedge clk);
      #1;
      chk("rf_we", rf_we_o, m_we);
      chk("rf_addr", rf_addr_o, m_addr);
      chk("rf_data", rf_data_o, m_data);
      chk("stall", stall_o, m_stall);
      chk("count", fifo_count_o, mq.size());
   endtask

   task automatic idle();
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   // asserted mid-cycle; leaves the bench one time unit after a rising edge
   task automatic do_reset();
      #2;
      rst = 1'b0;
      #1;
      chk("rst_we", rf_we_o, 1'b0);
      chk("rst_addr", rf_addr_o, 5'd0);
      chk("rst_data", rf_data_o, 32'd0);
      chk("rst_stall", stall_o, 1'b0);
      chk("rst_ready", mc_ready_o, 1'b0);
      chk("rst_count", fifo_count_o, 2'd0);
      model_clear();
      wb_valid_i = 1'b0;
      mc_valid_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("ready_after_rst", mc_ready_o, 1'b1);
      @(posedge clk);
      #1;
      chk("no_stale_we", rf_we_o, 1'b0);
   endtask

   initial begin
      logic [4:0] a1, a2;
      rst = 1'b0;
      wb_valid_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
      mc_valid_i = 1'b0; mc_addr_i = '0; mc_data_i = '0;
      model_clear();
      @(posedge clk);
      #1;
      do_reset();

      // bypass with empty FIFO
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEADBEEF);
      chk("byp_we", rf_we_o, 1'b1);
      chk("byp_addr", rf_addr_o, 5'd7);
      chk("byp_data", rf_data_o, 32'hDEADBEEF);
      chk("byp_count", fifo_count_o, 2'd0);

      // wb beats mc; mc result follows from the FIFO
      step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
      chk("prio_addr", rf_addr_o, 5'd3);
      chk("prio_count", fifo_count_o, 2'd1);
      idle();
      chk("prio2_addr", rf_addr_o, 5'd4);
      chk("prio2_data", rf_data_o, 32'h22);
      chk("prio2_count", fifo_count_o, 2'd0);

      // fill with wb held; ready drops after two pushes, then starvation drain
      step(1'b1, 5'd1, 32'h101, 1'b1, 5'd20, 32'hA0);
      step(1'b1, 5'd2, 32'h102, 1'b1, 5'd21, 32'hA1);
      step(1'b1, 5'd3, 32'h103, 1'b1, 5'd22, 32'hA2);
      chk("full_ready", mc_ready_o, 1'b0);
      chk("full_count", fifo_count_o, 2'd2);
      step(1'b1, 5'd4, 32'h104, 1'b0, 5'd0, 32'd0);
      chk("full_nostall", stall_o, 1'b0);
      step(1'b1, 5'd5, 32'h105, 1'b0, 5'd0, 32'd0);
      chk("full_stall", stall_o, 1'b1);
      step(1'b1, 5'd6, 32'h106, 1'b0, 5'd0, 32'd0);
      chk("drain_addr", rf_addr_o, 5'd20);
      chk("drain_unstall", stall_o, 1'b0);
      idle();
      chk("drain2_addr", rf_addr_o, 5'd21);
      idle();

      // starvation from count 1
      step(1'b1, 5'd8, 32'h8, 1'b1, 5'd9, 32'h99);
      for (int i = 0; i < 4; i++) begin
         chk("starve_pre", stall_o, 1'b0);
         step(1'b1, 5'(10 + i), 32'(i), 1'b0, 5'd0, 32'd0);
      end
      chk("starve_stall", stall_o, 1'b1);
      step(1'b1, 5'd30, 32'h30, 1'b0, 5'd0, 32'd0);
      chk("starve_head", rf_addr_o, 5'd9);
      chk("starve_head_d", rf_data_o, 32'h99);
      step(1'b1, 5'd31, 32'h31, 1'b0, 5'd0, 32'd0);
      chk("resume_addr", rf_addr_o, 5'd31);
      chk("resume_we", rf_we_o, 1'b1);

      // R0 write is consumed but not enabled
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
      chk("r0_we", rf_we_o, 1'b0);
      chk("r0_count", fifo_count_o, 2'd0);

      // reset with two parked entries; nothing stale afterwards
      step(1'b1, 5'd12, 32'h12, 1'b1, 5'd13, 32'h13);
      step(1'b1, 5'd14, 32'h14, 1'b1, 5'd15, 32'h15);
      chk("pre_rst_count", fifo_count_o, 2'd2);
      do_reset();
      idle();
      chk("post_rst_we", rf_we_o, 1'b0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            a1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            a2 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            step($urandom_range(0, 99) < 55, a1, $urandom,
                 $urandom_range(0, 99) < 60, a2, $urandom);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
